// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared length codes, FSM states, grant ids and byte-count helper for mem_ctrl
package mem_ctrl_pkg;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    // Length code 3 is treated as a word access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - pipeline request/response and byte-RAM signals of mem_ctrl
interface mem_ctrl_if #(parameter int ADDR_W = 32);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;

    logic              mem_read;
    logic              mem_write;
    logic              mem_signed;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_w_data;
    logic [31:0]       mem_r_data;
    logic              mem_done;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport master (
        output if_req, if_addr, mem_read, mem_write, mem_signed, mem_addr, mem_len, mem_w_data, ram_din,
        input  if_data, if_done, mem_r_data, mem_done, ram_addr, ram_wr, ram_dout
    );

    modport slave (
        input  if_req, if_addr, mem_read, mem_write, mem_signed, mem_addr, mem_len, mem_w_data, ram_din,
        output if_data, if_done, mem_r_data, mem_done, ram_addr, ram_wr, ram_dout
    );

endinterface

// File: rtl/mem_ctrl_ext.sv
// rtl/mem_ctrl_ext.sv - sign/zero extension of an assembled little-endian value by byte count
module mem_ext (
    input  logic [31:0] raw,
    input  logic [2:0]  nbytes,
    input  logic        sgn,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (nbytes)
            3'd1:    ext = {{24{sgn & raw[7]}}, raw[7:0]};
            3'd2:    ext = {{16{sgn & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IF/MEM arbiter serialising 1/2/4-byte accesses onto a byte-wide RAM; MEM_CTRL_RR_EN selects round-robin arbitration
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst_n,
    mem_ctrl_if.slave bus
);

    state_t            state, state_nxt;
    gnt_t              gnt_r;
    logic [ADDR_W-1:0] base;
    logic [2:0]        nb;
    logic              sgn_r;
    logic [31:0]       wdata;
    logic [2:0]        cyc;
    logic [31:0]       asm_r;

    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_wr_r;
    logic [7:0]        ram_dout_r;
    logic [31:0]       if_data_r, mem_r_data_r;
    logic              if_done_r, mem_done_r;

    logic              req_mem, pick_mem, grant, finish;
    logic [ADDR_W-1:0] g_addr;
    logic [2:0]        g_n;
    logic              g_sgn, g_wr;
    logic [4:0]        cap_sh, wr_sh;
    logic [31:0]       asm_cap, ext_val;
    logic [7:0]        wr_byte;

`ifdef MEM_CTRL_RR_EN
    gnt_t last_grant;
`endif

    assign req_mem = bus.mem_read | bus.mem_write;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        finish    = 1'b0;
`ifdef MEM_CTRL_RR_EN
        // On contention the port that did not win last time is served.
        pick_mem  = req_mem & (~bus.if_req | (last_grant == GNT_IF));
`else
        pick_mem  = req_mem;
`endif
        case (state)
            ST_IDLE: begin
                if (req_mem | bus.if_req) begin
                    grant     = 1'b1;
                    state_nxt = (pick_mem & bus.mem_write) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (cyc == nb + 3'd1) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (cyc == nb) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign g_addr = pick_mem ? bus.mem_addr : bus.if_addr;
    assign g_n    = pick_mem ? len_bytes(bus.mem_len) : 3'd4;
    assign g_sgn  = pick_mem & bus.mem_signed;
    assign g_wr   = pick_mem & bus.mem_write;

    // cyc counts edges since the grant; read data lags its address by two edges.
    assign cap_sh  = {cyc[1:0] - 2'd2, 3'b000};
    assign wr_sh   = {cyc[1:0], 3'b000};
    assign asm_cap = asm_r | (32'(bus.ram_din) << cap_sh);
    assign wr_byte = 8'(wdata >> wr_sh);

    mem_ext u_ext (
        .raw    (asm_cap),
        .nbytes (nb),
        .sgn    (sgn_r),
        .ext    (ext_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r        <= GNT_IF;
            base         <= '0;
            nb           <= 3'd0;
            sgn_r        <= 1'b0;
            wdata        <= 32'd0;
            cyc          <= 3'd0;
            asm_r        <= 32'd0;
            ram_addr_r   <= '0;
            ram_wr_r     <= 1'b0;
            ram_dout_r   <= 8'd0;
            if_data_r    <= 32'd0;
            mem_r_data_r <= 32'd0;
            if_done_r    <= 1'b0;
            mem_done_r   <= 1'b0;
`ifdef MEM_CTRL_RR_EN
            last_grant   <= GNT_IF;
`endif
        end else begin
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt_r      <= pick_mem ? GNT_MEM : GNT_IF;
                        base       <= g_addr;
                        nb         <= g_n;
                        sgn_r      <= g_sgn;
                        wdata      <= bus.mem_w_data;
                        cyc        <= 3'd1;
                        asm_r      <= 32'd0;
                        ram_addr_r <= g_addr;
                        ram_wr_r   <= g_wr;
                        if (g_wr) ram_dout_r <= bus.mem_w_data[7:0];
`ifdef MEM_CTRL_RR_EN
                        last_grant <= pick_mem ? GNT_MEM : GNT_IF;
`endif
                    end
                end
                ST_READ: begin
                    cyc <= cyc + 3'd1;
                    if (cyc >= 3'd2) asm_r <= asm_cap;
                    if (cyc < nb) ram_addr_r <= base + ADDR_W'(cyc);
                    if (finish) begin
                        if (gnt_r == GNT_MEM) begin
                            mem_r_data_r <= ext_val;
                            mem_done_r   <= 1'b1;
                        end else begin
                            if_data_r <= ext_val;
                            if_done_r <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    cyc <= cyc + 3'd1;
                    if (cyc < nb) begin
                        ram_addr_r <= base + ADDR_W'(cyc);
                        ram_dout_r <= wr_byte;
                        ram_wr_r   <= 1'b1;
                    end else begin
                        ram_wr_r <= 1'b0;
                    end
                    if (finish) mem_done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_wr     = ram_wr_r;
    assign bus.ram_dout   = ram_dout_r;
    assign bus.if_data    = if_data_r;
    assign bus.if_done    = if_done_r;
    assign bus.mem_r_data = mem_r_data_r;
    assign bus.mem_done   = mem_done_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a byte-wide synchronous RAM model
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  ram [0:4095];
    logic        pk_en;
    logic [11:0] pk_addr;
    logic [7:0]  pk_data;
    logic [39:0] wlog [$];

    always @(posedge clk) begin
        if (pk_en) begin
            ram[pk_addr] <= pk_data;
        end else if (bus.ram_wr) begin
            ram[bus.ram_addr[11:0]] <= bus.ram_dout;
            wlog.push_back({bus.ram_addr, bus.ram_dout});
        end
        bus.ram_din <= ram[bus.ram_addr[11:0]];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pk_en   = 1'b1;
        pk_addr = a;
        pk_data = d;
        @(negedge clk);
        pk_en   = 1'b0;
    endtask

    task automatic clear_reqs();
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'd0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_signed = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_len    = 2'd0;
        bus.mem_w_data = 32'd0;
    endtask

    // Requests are driven at a negedge; the next posedge is the grant edge.
    // edges = index of the edge that registered done (seen in the cycle after it).
    task automatic run(input string tag, input logic want_if, input logic hold,
                       input logic chk_data, input int exp_edges, input logic [31:0] exp_data);
        int          edges;
        logic [31:0] data;
        logic        other_seen;
        edges      = -1;
        data       = 32'd0;
        other_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) clear_reqs();
            if (want_if ? bus.mem_done : bus.if_done) other_seen = 1'b1;
            if (want_if ? bus.if_done : bus.mem_done) begin
                edges = k - 1;
                data  = want_if ? bus.if_data : bus.mem_r_data;
                if (hold) clear_reqs();
                break;
            end
        end
        check({tag, "_lat"}, edges, exp_edges);
        if (chk_data) check({tag, "_data"}, data, exp_data);
        check({tag, "_other_done"}, {31'd0, other_seen}, 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, want_if ? bus.if_done : bus.mem_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          mem_at, if_at, dones;
    logic [31:0] mem_d, if_d;
    logic [31:0] wrap_exp [4];

    initial begin
        rst_n = 1'b0;
        pk_en = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ctrl", {21'd0, bus.ram_wr, bus.if_done, bus.mem_done, bus.ram_dout}, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_mem_r_data", bus.mem_r_data, 32'd0);
        rst_n = 1'b1;

        poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h200, 8'h80); poke(12'h201, 8'h11); poke(12'h202, 8'h22); poke(12'h203, 8'h33);
        poke(12'h210, 8'h34); poke(12'h211, 8'h92);
        poke(12'hFFE, 8'hAA); poke(12'hFFF, 8'hBB); poke(12'h000, 8'hCC); poke(12'h001, 8'hDD);

        // IF word fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        run("if_fetch", 1'b1, 1'b0, 1'b1, 5, 32'h0000_0513);

        // byte and half loads
        bus.mem_read = 1'b1; bus.mem_len = 2'd0; bus.mem_signed = 1'b1; bus.mem_addr = 32'h200;
        run("lb", 1'b0, 1'b0, 1'b1, 2, 32'hFFFF_FF80);
        bus.mem_read = 1'b1; bus.mem_len = 2'd0; bus.mem_signed = 1'b0; bus.mem_addr = 32'h200;
        run("lbu", 1'b0, 1'b0, 1'b1, 2, 32'h0000_0080);
        bus.mem_read = 1'b1; bus.mem_len = 2'd1; bus.mem_signed = 1'b1; bus.mem_addr = 32'h210;
        run("lh", 1'b0, 1'b0, 1'b1, 3, 32'hFFFF_9234);

        // misaligned half store; write wins over a simultaneous read
        wlog.delete();
        bus.mem_write = 1'b1; bus.mem_read = 1'b1; bus.mem_len = 2'd1;
        bus.mem_addr = 32'h301; bus.mem_w_data = 32'hDEAD_BEEF;
        run("sh", 1'b0, 1'b0, 1'b0, 2, 32'd0);
        repeat (2) @(negedge clk);
        check("sh_nwrites", wlog.size(), 32'd2);
        if (wlog.size() >= 2) begin
            check("sh_w0_addr", wlog[0][39:8], 32'h301);
            check("sh_w0_data", {24'd0, wlog[0][7:0]}, 32'hEF);
            check("sh_w1_addr", wlog[1][39:8], 32'h302);
            check("sh_w1_data", {24'd0, wlog[1][7:0]}, 32'hBE);
        end
        bus.mem_read = 1'b1; bus.mem_len = 2'd1; bus.mem_signed = 1'b0; bus.mem_addr = 32'h301;
        run("lhu_back", 1'b0, 1'b0, 1'b1, 3, 32'h0000_BEEF);

        // simultaneous requests, each held until its own done
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_read = 1'b1; bus.mem_len = 2'd2; bus.mem_signed = 1'b0; bus.mem_addr = 32'h200;
        mem_at = 0; if_at = 0; mem_d = 32'd0; if_d = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.mem_done) begin mem_at = k; mem_d = bus.mem_r_data; bus.mem_read = 1'b0; end
            if (bus.if_done)  begin if_at = k;  if_d = bus.if_data;     bus.if_req = 1'b0;   end
            if (mem_at != 0 && if_at != 0) break;
        end
`ifdef MEM_CTRL_RR_EN
        check("arb_if_at", if_at, 32'd6);
        check("arb_mem_at", mem_at, 32'd13);
`else
        check("arb_mem_at", mem_at, 32'd6);
        check("arb_if_at", if_at, 32'd13);
`endif
        check("arb_mem_data", mem_d, 32'h3322_1180);
        check("arb_if_data", if_d, 32'h0000_0513);
        clear_reqs();
        @(negedge clk);

        // reset in the middle of a word read, request held across it
        bus.mem_read = 1'b1; bus.mem_len = 2'd2; bus.mem_signed = 1'b0; bus.mem_addr = 32'h200;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            dones += int'(bus.mem_done);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_ram_addr", bus.ram_addr, 32'd0);
        check("mid_rst_ctrl", {21'd0, bus.ram_wr, bus.if_done, bus.mem_done, bus.ram_dout}, 32'd0);
        check("mid_rst_if_data", bus.if_data, 32'd0);
        check("mid_rst_mem_r_data", bus.mem_r_data, 32'd0);
        @(negedge clk);
        dones += int'(bus.mem_done);
        check("mid_rst_no_done", dones, 32'd0);
        rst_n = 1'b1;
        run("post_rst", 1'b0, 1'b1, 1'b1, 5, 32'h3322_1180);

        // wrap-around word read with the request held through DONE
        wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;
        bus.mem_read = 1'b1; bus.mem_len = 2'd2; bus.mem_signed = 1'b1; bus.mem_addr = 32'hFFFF_FFFE;
        dones = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k <= 4) check($sformatf("wrap_addr%0d", k - 1), bus.ram_addr, wrap_exp[k-1]);
            if (k == 6) begin
                check("wrap_done", {31'd0, bus.mem_done}, 32'd1);
                check("wrap_data", bus.mem_r_data, 32'hDDCC_BBAA);
            end
            if (k == 7) check("wrap_idle_hold", bus.ram_addr, 32'h0000_0001);
            if (k == 8) check("wrap_regrant", bus.ram_addr, 32'hFFFF_FFFE);
            if (k <= 12) dones += int'(bus.mem_done);
            if (k == 13) check("wrap_second_done", {31'd0, bus.mem_done}, 32'd1);
        end
        check("wrap_single_done", dones, 32'd1);
        clear_reqs();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
